// File: rtl/jk_bank_arb.sv
// jk_bank_arb: four-requester round-robin arbiter in front of a bank of JK cells.
// Each granted request runs one fixed 3-cycle transaction: IDLE -> EXEC -> ACK -> IDLE.
// Optional feature: define JK_BANK_ARB_TGL_CNT_EN to count toggle (op 11) operations
// on tgl_cnt. Without it, tgl_cnt is tied to 0 and no counter logic is built.
module jk_bank_arb #(
   parameter int unsigned NUM_CELLS = 8,
   parameter int unsigned ADDR_W    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            req,
   input  logic [4*ADDR_W-1:0]   idx,
   input  logic [7:0]            op,
   output logic [3:0]            gnt,
   output logic [3:0]            ack,
   output logic                  err,
   output logic [NUM_CELLS-1:0]  q,
   output logic [NUM_CELLS-1:0]  q_bar,
   output logic                  busy,
   output logic [15:0]           tgl_cnt
);

   typedef enum logic [1:0] {StIdle, StExec, StAck} state_e;

   state_e                state_q, state_d;
   logic [1:0]            ptr_q, ptr_d;
   logic [1:0]            win_q, win_d;
   logic [ADDR_W-1:0]     idx_q, idx_d;
   logic [1:0]            op_q, op_d;
   logic [3:0]            gnt_q, gnt_d;
   logic [3:0]            ack_q, ack_d;
   logic                  err_q, err_d;
   logic [NUM_CELLS-1:0]  cells_q, cells_d;

   logic                  found;
   logic [1:0]            pick;
   logic [1:0]            cand;
   logic                  cell_valid;

   assign cell_valid = 32'(idx_q) < NUM_CELLS;

   // Round-robin pick: first asserted request at or above the pointer, mod 4.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      cand  = ptr_q;
      for (int unsigned k = 0; k < 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Next-state and registered-output logic for the transaction FSM.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      idx_d   = idx_q;
      op_d    = op_q;
      gnt_d   = gnt_q;
      ack_d   = ack_q;
      err_d   = err_q;
      cells_d = cells_q;
      unique case (state_q)
         StIdle: begin
            gnt_d = 4'b0000;
            ack_d = 4'b0000;
            err_d = 1'b0;
            if (found) begin
               win_d   = pick;
               idx_d   = idx[32'(pick)*ADDR_W +: ADDR_W];
               op_d    = op[32'(pick)*2 +: 2];
               gnt_d   = 4'(1) << pick;
               state_d = StExec;
            end
         end
         StExec: begin
            ack_d   = 4'(1) << win_q;
            ptr_d   = win_q + 2'd1;
            err_d   = !cell_valid;
            state_d = StAck;
            // Out-of-range indices match no cell, so q holds.
            for (int unsigned i = 0; i < NUM_CELLS; i++) begin
               if (cell_valid && 32'(idx_q) == i) begin
                  unique case (op_q)
                     2'b01:   cells_d[i] = 1'b0;
                     2'b10:   cells_d[i] = 1'b1;
                     2'b11:   cells_d[i] = ~cells_q[i];
                     default: cells_d[i] = cells_q[i];
                  endcase
               end
            end
         end
         StAck: begin
            gnt_d   = 4'b0000;
            ack_d   = 4'b0000;
            err_d   = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State register; synchronous reset wins over any in-flight transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= 2'd0;
         win_q   <= 2'd0;
         idx_q   <= '0;
         op_q    <= 2'b00;
         gnt_q   <= 4'b0000;
         ack_q   <= 4'b0000;
         err_q   <= 1'b0;
         cells_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         cells_q <= cells_d;
      end
   end

`ifdef JK_BANK_ARB_TGL_CNT_EN
   logic [15:0] tgl_q;
   logic        tgl_inc;

   assign tgl_inc = (state_q == StExec) && cell_valid && (op_q == 2'b11);

   // Saturating count of applied toggle operations.
   always_ff @(posedge clk) begin
      if (rst) begin
         tgl_q <= 16'h0000;
      end else if (tgl_inc && tgl_q != 16'hFFFF) begin
         tgl_q <= tgl_q + 16'd1;
      end
   end

   assign tgl_cnt = tgl_q;
`else
   assign tgl_cnt = 16'h0000;
`endif

   assign gnt   = gnt_q;
   assign ack   = ack_q;
   assign err   = err_q;
   assign q     = cells_q;
   assign q_bar = ~cells_q;
   assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_jk_bank_arb.sv
// Directed bench for jk_bank_arb: one 8-cell instance and one 6-cell instance
// (for the out-of-range index case). Expected values are hand-computed.
module tb_jk_bank_arb;

   logic        clk;
   logic        rst;

   logic [3:0]  req;
   logic [11:0] idx;
   logic [7:0]  op;
   logic [3:0]  gnt, ack;
   logic        err, busy;
   logic [7:0]  q, q_bar;
   logic [15:0] tgl_cnt;

   logic [3:0]  req6;
   logic [11:0] idx6;
   logic [7:0]  op6;
   logic [3:0]  gnt6, ack6;
   logic        err6, busy6;
   logic [5:0]  q6, q_bar6;
   logic [15:0] tgl_cnt6;

   int n_checks;
   int n_errors;
   logic [15:0] exp_tgl;

   jk_bank_arb #(.NUM_CELLS(8), .ADDR_W(3)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .idx     (idx),
      .op      (op),
      .gnt     (gnt),
      .ack     (ack),
      .err     (err),
      .q       (q),
      .q_bar   (q_bar),
      .busy    (busy),
      .tgl_cnt (tgl_cnt)
   );

   jk_bank_arb #(.NUM_CELLS(6), .ADDR_W(3)) u_dut6 (
      .clk     (clk),
      .rst     (rst),
      .req     (req6),
      .idx     (idx6),
      .op      (op6),
      .gnt     (gnt6),
      .ack     (ack6),
      .err     (err6),
      .q       (q6),
      .q_bar   (q_bar6),
      .busy    (busy6),
      .tgl_cnt (tgl_cnt6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample/drive 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction on the 8-cell instance with per-phase checks.
   task automatic txn(input string tag, input logic [3:0] r, input logic [11:0] iv,
                      input logic [7:0] ov, input logic [3:0] exp_g,
                      input logic [7:0] exp_q, input logic exp_err);
      req = r;
      idx = iv;
      op  = ov;
      tick();  // E0
      check({tag, ".gnt"}, 32'(gnt), 32'(exp_g));
      check({tag, ".busy_exec"}, 32'(busy), 32'd1);
      check({tag, ".ack_exec"}, 32'(ack), 32'd0);
      tick();  // E1
      check({tag, ".ack"}, 32'(ack), 32'(exp_g));
      check({tag, ".q"}, 32'(q), 32'(exp_q));
      check({tag, ".err"}, 32'(err), 32'(exp_err));
      check({tag, ".busy_ack"}, 32'(busy), 32'd1);
      req = 4'b0000;
      tick();  // E2
      check({tag, ".busy_idle"}, 32'(busy), 32'd0);
      check({tag, ".ack_idle"}, 32'(ack), 32'd0);
      check({tag, ".gnt_idle"}, 32'(gnt), 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
`ifdef JK_BANK_ARB_TGL_CNT_EN
      exp_tgl = 16'd2;
`else
      exp_tgl = 16'd0;
`endif
      rst  = 1'b1;
      req  = 4'b0000;
      idx  = 12'h000;
      op   = 8'h00;
      req6 = 4'b0000;
      idx6 = 12'h000;
      op6  = 8'h00;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst.q", 32'(q), 32'h00);
      check("rst.q_bar", 32'(q_bar), 32'hFF);
      check("rst.gnt", 32'(gnt), 32'd0);
      check("rst.ack", 32'(ack), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.tgl", 32'(tgl_cnt), 32'd0);
      tick();
      check("idle.busy", 32'(busy), 32'd0);

      // Requester 0 sets cell 3
      txn("set3", 4'b0001, 12'(3), 8'b0000_0010, 4'b0001, 8'h08, 1'b0);

      // Requester 2 toggles cell 3 twice (pointer is 1, so 2 wins)
      txn("tgl_a", 4'b0100, 12'(3 << 6), 8'b0011_0000, 4'b0100, 8'h00, 1'b0);
      txn("tgl_b", 4'b0100, 12'(3 << 6), 8'b0011_0000, 4'b0100, 8'h08, 1'b0);
      check("tgl_cnt", 32'(tgl_cnt), 32'(exp_tgl));

      // Round-robin with all four requesting continuously from reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rr.rst_tgl", 32'(tgl_cnt), 32'd0);
      req = 4'b1111;
      idx = 12'h000;
      op  = 8'h00;
      for (int k = 0; k < 14; k++) begin
         tick();
         if (k % 3 == 2) begin
            check($sformatf("rr.gnt%0d", k), 32'(gnt), 32'd0);
            check($sformatf("rr.ack%0d", k), 32'(ack), 32'd0);
         end else begin
            check($sformatf("rr.gnt%0d", k), 32'(gnt), 32'(1 << ((k / 3) % 4)));
            check($sformatf("rr.ack%0d", k), 32'(ack),
                  (k % 3 == 1) ? 32'(1 << ((k / 3) % 4)) : 32'd0);
         end
         if (k == 13) req = 4'b0000;
      end
      tick();
      check("rr.q", 32'(q), 32'h00);

      // Highest cell on an 8-cell bank (pointer now 1)
      txn("idx7", 4'b0010, 12'(7 << 3), 8'b0000_1000, 4'b0010, 8'h80, 1'b0);

      // Change idx/op mid-EXEC: latched values (cell 0, set) must apply
      req = 4'b1000;
      idx = 12'(0 << 9);
      op  = 8'b1000_0000;
      tick();
      check("late.gnt", 32'(gnt), 32'b1000);
      idx = 12'(5 << 9);
      op  = 8'b0100_0000;
      tick();
      check("late.ack", 32'(ack), 32'b1000);
      check("late.q", 32'(q), 32'h81);
      check("late.q_bar", 32'(q_bar), 32'h7E);
      req = 4'b0000;
      tick();

      // Reset during EXEC abandons the transaction
      req = 4'b0010;
      idx = 12'(2 << 3);
      op  = 8'b0000_1000;
      tick();
      check("rstx.gnt", 32'(gnt), 32'b0010);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstx.ack", 32'(ack), 32'd0);
      check("rstx.q", 32'(q), 32'h00);
      check("rstx.busy", 32'(busy), 32'd0);
      req = 4'b0011;
      op  = 8'h00;
      tick();
      check("rstx.regnt", 32'(gnt), 32'b0001);
      tick();
      check("rstx.reack", 32'(ack), 32'b0001);
      req = 4'b0000;
      tick();
      tick();

      // 6-cell bank: idx 6 is out of range
      req6 = 4'b0001;
      idx6 = 12'(6);
      op6  = 8'b0000_0010;
      tick();
      check("oor.gnt", 32'(gnt6), 32'b0001);
      tick();
      check("oor.ack", 32'(ack6), 32'b0001);
      check("oor.err", 32'(err6), 32'd1);
      check("oor.q", 32'(q6), 32'h00);
      req6 = 4'b0000;
      tick();
      check("oor.err_clr", 32'(err6), 32'd0);
      check("oor.ack_clr", 32'(ack6), 32'd0);

      // 6-cell bank: idx 5 is valid (pointer is 1, requester 1 wins)
      req6 = 4'b0010;
      idx6 = 12'(5 << 3);
      op6  = 8'b0000_1000;
      tick();
      tick();
      check("c5.ack", 32'(ack6), 32'b0010);
      check("c5.err", 32'(err6), 32'd0);
      check("c5.q", 32'(q6), 32'h20);
      req6 = 4'b0000;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: timeout reached, expected $finish earlier");
      $fatal(1);
   end

endmodule

// File: doc/jk_bank_arb.md
JK_BANK_ARB -- requirements
Module: jk_bank_arb

Interface
REQ-001 Parameter NUM_CELLS, default 8, SHALL set the number of JK cells in the bank (1..8).
REQ-002 Parameter ADDR_W, default 3, SHALL set the width of each cell-index field.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 req  input  4  SHALL carry one request line per requester (bit i = requester i).
REQ-006 idx  input  4*ADDR_W  SHALL carry the target cell per requester (requester i at bits [i*ADDR_W +: ADDR_W]).
REQ-007 op  input  8  SHALL carry the {J,K} code per requester (requester i at bits [2i+1:2i]).
REQ-008 gnt  output  4  SHALL be the registered one-hot grant, high from EXEC through ACK.
REQ-009 ack  output  4  SHALL be the registered one-hot completion pulse.
REQ-010 err  output  1  SHALL pulse with ack when the granted idx is >= NUM_CELLS.
REQ-011 q  output  NUM_CELLS  SHALL hold the JK cell states.
REQ-012 q_bar  output  NUM_CELLS  SHALL equal ~q, combinationally.
REQ-013 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-014 tgl_cnt  output  16  SHALL report the toggle count (see Configuration).

Function
REQ-015 The FSM SHALL have three states, IDLE -> EXEC -> ACK -> IDLE, with exactly one cycle in each of EXEC and ACK.
REQ-016 IDLE with req != 0: on the edge, SHALL pick a round-robin winner, latch its idx and op, set gnt to that winner, and go to EXEC.
REQ-017 IDLE with req == 0: SHALL stay in IDLE, with gnt, ack and err all 0.
REQ-018 Round-robin: priority SHALL start at the pointer and search upward mod 4; the pointer SHALL be 0 after reset and SHALL become winner+1 mod 4 on entry to ACK.
REQ-019 EXEC edge, with a latched idx < NUM_CELLS, SHALL apply the latched op to q[idx]: 00 hold, 01 clear, 10 set, 11 invert; all other cells SHALL hold.
REQ-020 EXEC edge, with a latched idx >= NUM_CELLS, SHALL leave q unchanged and set err for the ACK cycle.
REQ-021 Entry to ACK SHALL assert ack[winner] for exactly one cycle; the ACK edge SHALL clear gnt, ack and err and return to IDLE.
REQ-022 Latency SHALL be fixed: req sampled at edge E0, q updated at E1, ack high between E1 and E2, IDLE at E2, next arbitration at E3.
REQ-023 Requesters SHALL hold req, idx and op stable until ack is sampled high; the block SHALL ignore req, idx and op changes in EXEC and ACK.
REQ-024 Simultaneous requests SHALL be served one per 3-cycle transaction, in round-robin order, with no starvation.

Reset
REQ-025 rst high at an edge SHALL force state IDLE, pointer 0, q 0, gnt 0, ack 0, err 0 and tgl_cnt 0, with priority over all other activity.
REQ-026 rst asserted during EXEC or ACK SHALL abandon the transaction: no ack issued, and no q update at that edge.

Configuration
REQ-027 With JK_BANK_ARB_TGL_CNT_EN defined, tgl_cnt SHALL increment on every EXEC edge that applies op 11 to a valid cell, saturating at 16'hFFFF.
REQ-028 Without JK_BANK_ARB_TGL_CNT_EN, tgl_cnt SHALL be constant 0 and no counter logic SHALL be synthesized; the port list SHALL be unchanged.

Verification
REQ-029 Reset, then req=4'b0001, idx0=3, op0=10 -> q=8'h08 after E1, ack=4'b0001 for one cycle, busy high for 2 cycles.
REQ-030 Start q=8'h08, then requester 2 sends idx=3, op=11 twice -> q=8'h00 then 8'h08; tgl_cnt=2 with the macro, 0 without.
REQ-031 req=4'b1111 held (re-raised after each ack) from reset -> grant order 0,1,2,3,0, with each grant 3 cycles apart.
REQ-032 NUM_CELLS=8, idx=7 -> cell 7 updated; NUM_CELLS=6, idx=6, op=10 -> q unchanged, err=1 coincident with ack.
REQ-033 rst pulsed in the EXEC cycle -> no ack, q=0, next request granted to requester 0 first.
REQ-034 Change idx/op of the granted requester during EXEC -> the originally latched values are applied.
